// File: rtl/home_cell_broadcaster.sv
// Home cell broadcaster: reads the cell position RAM (count word, then N particles)
// and streams every particle twice (phase 0, phase 1) for each reference particle.
module home_cell_broadcaster #(
    parameter int PARTICLE_ID_WIDTH = 4,
    parameter int OFFSET_WIDTH      = 8,
    parameter int RAM_LATENCY       = 2,
    parameter int ADDR_WIDTH        = PARTICLE_ID_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [3*OFFSET_WIDTH-1:0]    rd_data,
    output logic [3*OFFSET_WIDTH-1:0]    raw_home_pos,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         phase,
    output logic                         prev_phase,
    output logic                         reading_particle_num,
    output logic                         bcast_valid,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        WAIT_NUM,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_next;

    logic [PARTICLE_ID_WIDTH-1:0] num_cnt;
    logic [PARTICLE_ID_WIDTH-1:0] pid_cnt;
    logic [PARTICLE_ID_WIDTH-1:0] ref_cnt;
    logic                         ph_cnt;

    logic                         tag_valid [RAM_LATENCY];
    logic                         tag_num   [RAM_LATENCY];
    logic [PARTICLE_ID_WIDTH-1:0] tag_pid   [RAM_LATENCY];
    logic [PARTICLE_ID_WIDTH-1:0] tag_ref   [RAM_LATENCY];
    logic                         tag_ph    [RAM_LATENCY];

    logic                         issue_num;
    logic                         pipe_empty;
    logic                         num_arrive;
    logic                         last_pid;
    logic                         last_ref;
    logic [PARTICLE_ID_WIDTH-1:0] rd_count;

    // The count lives in the low bits of offset_x, the most significant tuple field.
    assign rd_count   = rd_data[2*OFFSET_WIDTH +: PARTICLE_ID_WIDTH];
    assign num_arrive = tag_valid[RAM_LATENCY-1] && tag_num[RAM_LATENCY-1];
    assign last_pid   = (pid_cnt == num_cnt - PARTICLE_ID_WIDTH'(1));
    assign last_ref   = (ref_cnt == num_cnt - PARTICLE_ID_WIDTH'(1));
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            if (tag_valid[i]) pipe_empty = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        issue_num  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RD_NUM;
            end
            RD_NUM: begin
                rd_en      = 1'b1;
                issue_num  = 1'b1;
                state_next = WAIT_NUM;
            end
            WAIT_NUM: begin
                if (num_arrive) state_next = (rd_count == '0) ? FIN : STREAM;
            end
            STREAM: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_WIDTH'(pid_cnt) + ADDR_WIDTH'(1);
                if (last_pid && ph_cnt && last_ref) state_next = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters walk pid fastest, then phase, then reference, with no gap between passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_cnt <= '0;
            pid_cnt <= '0;
            ref_cnt <= '0;
            ph_cnt  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT_NUM && num_arrive) begin
                num_cnt <= rd_count;
                pid_cnt <= '0;
                ref_cnt <= '0;
                ph_cnt  <= 1'b0;
            end else if (state == STREAM) begin
                if (last_pid) begin
                    pid_cnt <= '0;
                    if (ph_cnt) begin
                        ph_cnt  <= 1'b0;
                        ref_cnt <= ref_cnt + PARTICLE_ID_WIDTH'(1);
                    end else begin
                        ph_cnt <= 1'b1;
                    end
                end else begin
                    pid_cnt <= pid_cnt + PARTICLE_ID_WIDTH'(1);
                end
            end
        end
    end

    // Tags travel alongside the RAM so each returning word knows what it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_num[i]   <= 1'b0;
                tag_pid[i]   <= '0;
                tag_ref[i]   <= '0;
                tag_ph[i]    <= 1'b0;
            end
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_num[i]   <= tag_num[i-1];
                tag_pid[i]   <= tag_pid[i-1];
                tag_ref[i]   <= tag_ref[i-1];
                tag_ph[i]    <= tag_ph[i-1];
            end
            tag_valid[0] <= rd_en;
            tag_num[0]   <= issue_num;
            tag_pid[0]   <= pid_cnt;
            tag_ref[0]   <= ref_cnt;
            tag_ph[0]    <= ph_cnt;
        end
    end

    // Broadcast register; phase drops back to 0 on entry to FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_home_pos         <= '0;
            particle_id          <= '0;
            ref_id               <= '0;
            phase                <= 1'b0;
            prev_phase           <= 1'b0;
            reading_particle_num <= 1'b0;
            bcast_valid          <= 1'b0;
        end else begin
            prev_phase           <= phase;
            reading_particle_num <= 1'b0;
            bcast_valid          <= 1'b0;
            if (tag_valid[RAM_LATENCY-1]) begin
                raw_home_pos <= rd_data;
                if (tag_num[RAM_LATENCY-1]) begin
                    reading_particle_num <= 1'b1;
                    particle_id          <= '0;
                    ref_id               <= '0;
                    phase                <= 1'b0;
                end else begin
                    bcast_valid <= 1'b1;
                    particle_id <= tag_pid[RAM_LATENCY-1];
                    ref_id      <= tag_ref[RAM_LATENCY-1];
                    phase       <= tag_ph[RAM_LATENCY-1];
                end
            end else if (state == DRAIN && pipe_empty) begin
                phase <= 1'b0;
            end
        end
    end

endmodule
